// File: rtl/literal_seq_pkg.sv
// Shared definitions for the BITS literal sequencer.
// Holds the sequencer state encoding and the width constants that fix the
// group size, the assembly window, the decoded value and the bit-count field.
package literal_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_FIRE  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int GROUP_W     = 5;
  localparam int MAX_GROUPS  = 16;
  localparam int WINDOW_W    = GROUP_W * MAX_GROUPS;
  localparam int NUM_W       = 64;
  localparam int BITS_USED_W = 7;

endpackage

// File: rtl/literal_sequencer_number.sv
// number_top: turns a left-aligned window of 5-bit BITS groups into a value.
// Each group is {continuation, nibble}. Starting at the most significant
// group, nibbles are appended while every earlier group carried continuation
// 1; the first group with continuation 0 is the last one taken. Zero groups
// after it are therefore ignored. The result is registered on enable.
// Ports:
//   clk, resetB      - clock, synchronous active-high reset
//   enable           - capture the decoded value this cycle
//   number_from_bits - assembly window, group 0 in the top bits
//   number           - registered decoded value
module number_top import literal_seq_pkg::*; #(
  parameter int MAX_GROUPS = 16
) (
  input  logic                            clk,
  input  logic                            resetB,
  input  logic                            enable,
  input  logic [GROUP_W*MAX_GROUPS-1:0]   number_from_bits,
  output logic [4*MAX_GROUPS-1:0]         number
);

  localparam int WIN_W = GROUP_W * MAX_GROUPS;
  localparam int VAL_W = 4 * MAX_GROUPS;

  logic [VAL_W-1:0]   chain_s;
  logic [VAL_W-1:0]   number_r;
  logic               live_s;
  logic [GROUP_W-1:0] grp_s;

  // Nibble chain: shift in nibbles until the group after a continuation-0 group
  always_comb begin
    chain_s = '0;
    live_s  = 1'b1;
    grp_s   = '0;
    for (int g = 0; g < MAX_GROUPS; g++) begin
      grp_s = number_from_bits[WIN_W-1-GROUP_W*g -: GROUP_W];
      if (live_s) begin
        chain_s = {chain_s[VAL_W-5:0], grp_s[3:0]};
        live_s  = grp_s[4];
      end else begin
        live_s  = 1'b0;
      end
    end
  end

  // Output register, updated only on the enable pulse
  always_ff @(posedge clk) begin
    if (resetB) begin
      number_r <= '0;
    end else if (enable) begin
      number_r <= chain_s;
    end
  end

  assign number = number_r;

endmodule

// File: rtl/literal_sequencer.sv
// literal_sequencer: pulls a serial BITS literal through a valid/ready bit
// interface, assembles it into the left-aligned window, fires number_top
// once, and returns the decoded value with the number of bits consumed.
// Ports:
//   clk, resetB     - clock, synchronous active-high reset
//   start           - begin a literal (honoured only when idle)
//   bit_in/valid    - serial stream, MSB first; bit_ready accepts it
//   literal         - decoded value, bits_used = 5 * group count
//   literal_valid   - result valid until literal_ready
//   err             - one-cycle pulse when the literal exceeds MAX_GROUPS
module literal_sequencer import literal_seq_pkg::*; #(
  parameter int MAX_GROUPS = 16
) (
  input  logic                   clk,
  input  logic                   resetB,
  input  logic                   start,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic [4*MAX_GROUPS-1:0] literal,
  output logic [BITS_USED_W-1:0] bits_used,
  output logic                   literal_valid,
  input  logic                   literal_ready,
  output logic                   err
);

  localparam int WIN_W = GROUP_W * MAX_GROUPS;
  localparam int VAL_W = 4 * MAX_GROUPS;
  localparam int IDX_W = $clog2(WIN_W);
  localparam int GRP_W = $clog2(MAX_GROUPS);

  state_e               state_r;
  state_e               state_s;
  logic [WIN_W-1:0]     window_r;
  logic [GRP_W-1:0]     grp_cnt_r;
  logic [2:0]           bit_cnt_r;
  logic                 cont_r;
  logic [VAL_W-1:0]     literal_r;
  logic [BITS_USED_W-1:0] bits_used_r;
  logic                 err_r;
  logic                 accept_s;
  logic                 grp_done_s;
  logic                 last_grp_s;
  logic                 enable_s;
  logic [IDX_W-1:0]     idx_s;
  logic [VAL_W-1:0]     number_s;

  assign accept_s   = bit_valid && (state_r == ST_SHIFT);
  assign grp_done_s = accept_s && (bit_cnt_r == 3'd4);
  assign last_grp_s = (grp_cnt_r == GRP_W'(MAX_GROUPS - 1));
  assign enable_s   = (state_r == ST_FIRE);
  // Window fills from the top: group 0 bit 0 lands in the MSB
  assign idx_s      = IDX_W'(WIN_W - 1)
                    - (IDX_W'(GROUP_W) * IDX_W'(grp_cnt_r) + IDX_W'(bit_cnt_r));

  number_top #(.MAX_GROUPS(MAX_GROUPS)) u_number_top (
    .clk              (clk),
    .resetB           (resetB),
    .enable           (enable_s),
    .number_from_bits (window_r),
    .number           (number_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (resetB) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (grp_done_s) begin
          if (!cont_r) begin
            state_s = ST_FIRE;
          end else if (last_grp_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_FIRE: state_s = ST_WAIT;
      ST_WAIT: state_s = ST_DONE;
      ST_DONE: begin
        if (literal_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Window, counters, continuation latch, result capture and overflow pulse
  always_ff @(posedge clk) begin
    if (resetB) begin
      window_r    <= '0;
      grp_cnt_r   <= '0;
      bit_cnt_r   <= 3'd0;
      cont_r      <= 1'b0;
      literal_r   <= '0;
      bits_used_r <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            window_r  <= '0;
            grp_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            cont_r    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (accept_s) begin
            window_r[idx_s] <= bit_in;
            if (bit_cnt_r == 3'd0) begin
              cont_r <= bit_in;
            end
            if (bit_cnt_r == 3'd4) begin
              bit_cnt_r <= 3'd0;
              // grp_cnt stays on the final group so bits_used can be derived from it
              if (cont_r && !last_grp_s) begin
                grp_cnt_r <= grp_cnt_r + GRP_W'(1);
              end
              if (cont_r && last_grp_s) begin
                err_r <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        ST_WAIT: begin
          literal_r   <= number_s;
          bits_used_r <= BITS_USED_W'(GROUP_W) * (BITS_USED_W'(grp_cnt_r) + 7'd1);
        end
        default: begin
          literal_r <= literal_r;
        end
      endcase
    end
  end

  assign bit_ready     = (state_r == ST_SHIFT);
  assign literal_valid = (state_r == ST_DONE);
  assign literal       = literal_r;
  assign bits_used     = bits_used_r;
  assign err           = err_r;

endmodule

// File: tb/tb_literal_sequencer.sv
// Directed bench for literal_sequencer: each scenario task drives a BITS
// literal and compares outputs against hand-computed values.
module tb_literal_sequencer;

  logic        clk = 1'b0;
  logic        resetB, start, bit_in, bit_valid, literal_ready;
  logic        bit_ready, literal_valid, err;
  logic [63:0] literal;
  logic [6:0]  bits_used;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int lv_cnt = 0;

  literal_sequencer #(.MAX_GROUPS(16)) dut (
    .clk           (clk),
    .resetB        (resetB),
    .start         (start),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .bit_ready     (bit_ready),
    .literal       (literal),
    .bits_used     (bits_used),
    .literal_valid (literal_valid),
    .literal_ready (literal_ready),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (dut.enable_s) en_cnt++;
    if (err) err_cnt++;
    if (literal_valid) lv_cnt++;
  end

  localparam logic [79:0] SEQ_2021 = {15'b101111111000101, 65'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_literal();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [79:0] seq, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      bit_in    = seq[79-i];
      bit_valid = 1'b1;
      tick();
      if (gap) begin
        bit_valid = 1'b0;
        tick();
      end
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!literal_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (literal_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout literal_valid=%b required 1", name, literal_valid);
    end
  endtask

  task automatic handshake();
    literal_ready = 1'b1;
    tick();
    literal_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetB = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; literal_ready = 1'b0;
    tick(); tick();
    resetB = 1'b0;
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL reset_bit_ready got %b exp 0", bit_ready); end
    checks++; if (literal !== 64'd0) begin errors++; $display("FAIL reset_literal got %h exp 0", literal); end
    checks++; if (bits_used !== 7'd0) begin errors++; $display("FAIL reset_bits_used got %0d exp 0", bits_used); end
    checks++; if (literal_valid !== 1'b0) begin errors++; $display("FAIL reset_literal_valid got %b exp 0", literal_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_example();
    int en0;
    en0 = en_cnt;
    start_literal();
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL ex_bit_ready got %b exp 1", bit_ready); end
    send_bits(SEQ_2021, 15, 1'b0);
    checks++; if (literal_valid !== 1'b0) begin errors++; $display("FAIL ex_lat_n1 got %b exp 0", literal_valid); end
    tick();
    checks++; if (literal_valid !== 1'b0) begin errors++; $display("FAIL ex_lat_n2 got %b exp 0", literal_valid); end
    tick();
    checks++; if (literal_valid !== 1'b1) begin errors++; $display("FAIL ex_lat_n3 got %b exp 1", literal_valid); end
    checks++; if (literal !== 64'd2021) begin errors++; $display("FAIL ex_literal got %h exp %h", literal, 64'd2021); end
    checks++; if (bits_used !== 7'd15) begin errors++; $display("FAIL ex_bits_used got %0d exp 15", bits_used); end
    checks++; if (en_cnt - en0 !== 1) begin errors++; $display("FAIL ex_enable_count got %0d exp 1", en_cnt - en0); end
    handshake();
    checks++; if (literal_valid !== 1'b0) begin errors++; $display("FAIL ex_valid_drop got %b exp 0", literal_valid); end
  endtask

  task automatic test_single();
    logic [79:0] seq;
    seq = {5'b00001, 75'd0};
    start_literal();
    send_bits(seq, 5, 1'b0);
    wait_valid("single1");
    checks++; if (literal !== 64'd1) begin errors++; $display("FAIL single1_literal got %h exp 1", literal); end
    checks++; if (bits_used !== 7'd5) begin errors++; $display("FAIL single1_bits_used got %0d exp 5", bits_used); end
    handshake();
    // back-to-back: start in the first cycle after the handshake
    seq = {5'b00000, 75'd0};
    start_literal();
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL b2b_bit_ready got %b exp 1", bit_ready); end
    send_bits(seq, 5, 1'b0);
    wait_valid("single0");
    checks++; if (literal !== 64'd0) begin errors++; $display("FAIL single0_literal got %h exp 0", literal); end
    checks++; if (bits_used !== 7'd5) begin errors++; $display("FAIL single0_bits_used got %0d exp 5", bits_used); end
    handshake();
  endtask

  task automatic test_max();
    logic [79:0] seq;
    int err0;
    err0 = err_cnt;
    seq = 80'hFFFF_FFFF_FFFF_FFFF_FFEF;
    start_literal();
    send_bits(seq, 80, 1'b0);
    wait_valid("max");
    checks++; if (literal !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL max_literal got %h exp ffffffffffffffff", literal); end
    checks++; if (bits_used !== 7'd80) begin errors++; $display("FAIL max_bits_used got %0d exp 80", bits_used); end
    checks++; if (err_cnt !== err0) begin errors++; $display("FAIL max_no_err got %0d exp %0d", err_cnt, err0); end
    handshake();
  endtask

  task automatic test_overflow();
    logic [79:0] seq;
    int en0, err0, lv0;
    seq = '0;
    for (int g = 0; g < 16; g++) seq[79-5*g] = 1'b1;
    en0 = en_cnt; err0 = err_cnt; lv0 = lv_cnt;
    start_literal();
    send_bits(seq, 80, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_pulse got %b exp 1", err); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL ovf_idle got %b exp 0", bit_ready); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_drop got %b exp 0", err); end
    tick(); tick(); tick();
    checks++; if (err_cnt - err0 !== 1) begin errors++; $display("FAIL ovf_err_count got %0d exp 1", err_cnt - err0); end
    checks++; if (en_cnt !== en0) begin errors++; $display("FAIL ovf_no_enable got %0d exp %0d", en_cnt, en0); end
    checks++; if (lv_cnt !== lv0) begin errors++; $display("FAIL ovf_no_valid got %0d exp %0d", lv_cnt, lv0); end
  endtask

  task automatic test_backpressure();
    start_literal();
    send_bits(SEQ_2021, 15, 1'b1);
    wait_valid("bp");
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (literal_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", c, literal_valid); end
      checks++; if (literal !== 64'd2021) begin errors++; $display("FAIL bp_hold_literal cyc %0d got %h exp %h", c, literal, 64'd2021); end
      tick();
    end
    start = 1'b0;
    checks++; if (bits_used !== 7'd15) begin errors++; $display("FAIL bp_bits_used got %0d exp 15", bits_used); end
    handshake();
    checks++; if (literal_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b exp 0", literal_valid); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL bp_start_ignored got %b exp 0", bit_ready); end
  endtask

  task automatic test_reset_mid();
    int en0;
    start_literal();
    send_bits(SEQ_2021, 7, 1'b0);
    en0 = en_cnt;
    resetB = 1'b1;
    tick();
    resetB = 1'b0;
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL rm_bit_ready got %b exp 0", bit_ready); end
    checks++; if (literal !== 64'd0) begin errors++; $display("FAIL rm_literal got %h exp 0", literal); end
    checks++; if (bits_used !== 7'd0) begin errors++; $display("FAIL rm_bits_used got %0d exp 0", bits_used); end
    checks++; if (literal_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", literal_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_err got %b exp 0", err); end
    tick(); tick();
    checks++; if (en_cnt !== en0) begin errors++; $display("FAIL rm_no_enable got %0d exp %0d", en_cnt, en0); end
    start_literal();
    send_bits(SEQ_2021, 15, 1'b0);
    wait_valid("rm_after");
    checks++; if (literal !== 64'd2021) begin errors++; $display("FAIL rm_after_literal got %h exp %h", literal, 64'd2021); end
    checks++; if (bits_used !== 7'd15) begin errors++; $display("FAIL rm_after_bits_used got %0d exp 15", bits_used); end
    checks++; if (en_cnt - en0 !== 1) begin errors++; $display("FAIL rm_after_enable got %0d exp 1", en_cnt - en0); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_example();
    test_single();
    test_max();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
